// File: rtl/aca_lock_ctrl_if.sv
// Bundle between aca_lock_ctrl and its environment: key loader, two requesters,
// the external locked adder and the response consumer.
interface aca_lock_ctrl_if #(
  parameter int KEY_W  = 32,
  parameter int DATA_W = 16
);
  logic              key_load_i;
  logic              key_bit_i;
  logic              key_valid_o;
  logic              req0_valid_i;
  logic [DATA_W-1:0] req0_a_i;
  logic [DATA_W-1:0] req0_b_i;
  logic              req1_valid_i;
  logic [DATA_W-1:0] req1_a_i;
  logic [DATA_W-1:0] req1_b_i;
  logic              req0_ready_o;
  logic              req1_ready_o;
  logic [DATA_W-1:0] add1_o;
  logic [DATA_W-1:0] add2_o;
  logic [KEY_W-1:0]  key_o;
  logic [DATA_W:0]   result_i;
  logic              resp_valid_o;
  logic              resp_id_o;
  logic [DATA_W:0]   result_o;
  logic              resp_ready_i;
  logic              busy_o;

  modport slave (
    input  key_load_i, key_bit_i,
    input  req0_valid_i, req0_a_i, req0_b_i,
    input  req1_valid_i, req1_a_i, req1_b_i,
    input  result_i, resp_ready_i,
    output key_valid_o, req0_ready_o, req1_ready_o,
    output add1_o, add2_o, key_o,
    output resp_valid_o, resp_id_o, result_o, busy_o
  );

  modport master (
    output key_load_i, key_bit_i,
    output req0_valid_i, req0_a_i, req0_b_i,
    output req1_valid_i, req1_a_i, req1_b_i,
    output result_i, resp_ready_i,
    input  key_valid_o, req0_ready_o, req1_ready_o,
    input  add1_o, add2_o, key_o,
    input  resp_valid_o, resp_id_o, result_o, busy_o
  );
endinterface

// File: rtl/aca_lock_ctrl.sv
// Key loader and two-requester round-robin front end for an external locked adder.
// The key is shifted in serially and exposed atomically; the adder result is sampled after SETTLE cycles.
module aca_lock_ctrl #(
  parameter int KEY_W  = 32,
  parameter int DATA_W = 16,
  parameter int SETTLE = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  aca_lock_ctrl_if.slave bus
);
  localparam int             CW       = $clog2(KEY_W);
  localparam logic [CW-1:0]  BIT_LAST = CW'(KEY_W - 1);
  localparam logic [3:0]     SETTLE_L = 4'(SETTLE);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARB, S_SETTLE, S_RESP} state_t;

  state_t            r_state;
  logic [KEY_W-1:0]  r_shadow;
  logic [KEY_W-1:0]  r_key;
  logic [CW-1:0]     r_bitcnt;
  logic [3:0]        r_settle;
  logic              r_key_valid;
  logic              r_prio;
  logic              r_id;
  logic              r_resp_id;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_add1;
  logic [DATA_W-1:0] r_add2;
  logic [DATA_W:0]   r_result;

  logic              w_arb;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic [KEY_W-1:0]  w_shadow_nxt;

  // A key load request in ARB pre-empts any grant in the same cycle.
  always_comb begin
    w_arb        = (r_state == S_ARB) && !bus.key_load_i;
    w_gnt0       = w_arb && bus.req0_valid_i && (!bus.req1_valid_i || !r_prio);
    w_gnt1       = w_arb && bus.req1_valid_i && (!bus.req0_valid_i ||  r_prio);
    w_xfer       = w_gnt0 || w_gnt1;
    w_shadow_nxt = {r_shadow[KEY_W-2:0], bus.key_bit_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_shadow     <= '0;
      r_key        <= '0;
      r_bitcnt     <= '0;
      r_settle     <= '0;
      r_key_valid  <= 1'b0;
      r_prio       <= 1'b0;
      r_id         <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_add1       <= '0;
      r_add2       <= '0;
      r_result     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.key_load_i) begin
            r_state     <= S_LOAD;
            r_bitcnt    <= '0;
            r_key_valid <= 1'b0;
          end
        end
        S_LOAD: begin
          r_shadow <= w_shadow_nxt;
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_bitcnt == BIT_LAST) begin
            r_key       <= w_shadow_nxt;
            r_key_valid <= 1'b1;
            r_state     <= S_ARB;
          end
        end
        S_ARB: begin
          if (bus.key_load_i) begin
            r_state     <= S_LOAD;
            r_bitcnt    <= '0;
            r_key_valid <= 1'b0;
          end else if (w_xfer) begin
            r_add1   <= w_gnt1 ? bus.req1_a_i : bus.req0_a_i;
            r_add2   <= w_gnt1 ? bus.req1_b_i : bus.req0_b_i;
            r_id     <= w_gnt1;
            r_prio   <= ~w_gnt1;
            r_settle <= SETTLE_L;
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_settle <= r_settle - 1'b1;
          if (r_settle == 4'd1) begin
            r_result     <= bus.result_i;
            r_resp_id    <= r_id;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_ARB;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready_o = w_gnt0;
  assign bus.req1_ready_o = w_gnt1;
  assign bus.key_valid_o  = r_key_valid;
  assign bus.key_o        = r_key;
  assign bus.add1_o       = r_add1;
  assign bus.add2_o       = r_add2;
  assign bus.result_o     = r_result;
  assign bus.resp_id_o    = r_resp_id;
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.busy_o       = (r_state != S_IDLE) && (r_state != S_ARB);
endmodule

// File: tb/tb_aca_lock_ctrl.sv
// Directed bench for aca_lock_ctrl with an a+b adder model and a response scoreboard.
module tb_aca_lock_ctrl;
  localparam int KEY_W  = 32;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic            id;
    logic [DATA_W:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  aca_lock_ctrl_if #(.KEY_W(KEY_W), .DATA_W(DATA_W)) bus ();

  assign bus.result_i = {1'b0, bus.add1_o} + {1'b0, bus.add2_o};

  aca_lock_ctrl #(.KEY_W(KEY_W), .DATA_W(DATA_W), .SETTLE(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is in the first cycle after the transfer edge (cycle 1 of the latency count).
  task automatic wait_resp(input int exp_lat, input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (!bus.resp_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_vld"}, bus.resp_valid_o, 1);
    if (bus.resp_valid_o) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_res"}, bus.result_o, e.res);
        chk({tag, "_id"},  bus.resp_id_o, e.id);
      end
    end
  endtask

  initial begin
    logic [KEY_W-1:0] key;
    logic             key_moved;
    bus.key_load_i   = 0;
    bus.key_bit_i    = 0;
    bus.req0_valid_i = 0;
    bus.req0_a_i     = 0;
    bus.req0_b_i     = 0;
    bus.req1_valid_i = 0;
    bus.req1_a_i     = 0;
    bus.req1_b_i     = 0;
    bus.resp_ready_i = 1;

    // reset state
    tick();
    tick();
    chk("rst_key",       bus.key_o, 0);
    chk("rst_key_valid", bus.key_valid_o, 0);
    chk("rst_busy",      bus.busy_o, 0);
    chk("rst_resp_vld",  bus.resp_valid_o, 0);
    chk("rst_add1",      bus.add1_o, 0);
    chk("rst_result",    bus.result_o, 0);
    rst = 0;
    bus.req0_valid_i = 1;
    #1;
    chk("idle_ready", {bus.req1_ready_o, bus.req0_ready_o}, 2'b00);
    bus.req0_valid_i = 0;

    // serial key load, MSB first
    key = 32'h1812B8A4;
    key_moved = 0;
    bus.key_load_i = 1;
    tick();
    bus.key_load_i = 0;
    chk("load_busy", bus.busy_o, 1);
    for (int i = KEY_W - 1; i >= 0; i--) begin
      bus.key_bit_i = key[i];
      if (bus.key_o !== '0) key_moved = 1;
      tick();
    end
    chk("load_key_hold", key_moved, 0);
    chk("load_key",       bus.key_o, key);
    chk("load_key_valid", bus.key_valid_o, 1);
    chk("arb_busy",       bus.busy_o, 0);

    // arbitration, both requesters valid continuously
    bus.req0_a_i = 16'h5555; bus.req0_b_i = 16'hAAAA;
    bus.req1_a_i = 16'h8943; bus.req1_b_i = 16'hFFFF;
    bus.req0_valid_i = 1;
    bus.req1_valid_i = 1;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk($sformatf("rr_gnt%0d", g), {bus.req1_ready_o, bus.req0_ready_o},
          (g % 2) ? 2'b10 : 2'b01);
      if (g % 2) exp_q.push_back('{id: 1'b1, res: 17'h18942});
      else       exp_q.push_back('{id: 1'b0, res: 17'h0FFFF});
      tick();
      wait_resp(-1, $sformatf("rr%0d", g));
      tick();
    end
    bus.req0_valid_i = 0;
    bus.req1_valid_i = 0;
    chk("rr_resp_drop", bus.resp_valid_o, 0);

    // single operation on requester 0
    bus.req0_a_i = 16'h29AF; bus.req0_b_i = 16'h7A1B;
    bus.req0_valid_i = 1;
    #1;
    chk("single_gnt", {bus.req1_ready_o, bus.req0_ready_o}, 2'b01);
    exp_q.push_back('{id: 1'b0, res: 17'h0A3CA});
    tick();
    bus.req0_valid_i = 0;
    chk("single_add1", bus.add1_o, 16'h29AF);
    chk("single_add2", bus.add2_o, 16'h7A1B);
    chk("single_busy", bus.busy_o, 1);
    wait_resp(3, "single");
    tick();
    chk("single_done", bus.resp_valid_o, 0);

    // backpressure on the response channel
    bus.resp_ready_i = 0;
    bus.req1_a_i = 16'h1234; bus.req1_b_i = 16'h4321;
    bus.req1_valid_i = 1;
    #1;
    chk("bp_gnt", {bus.req1_ready_o, bus.req0_ready_o}, 2'b10);
    tick();
    bus.req0_valid_i = 1;
    begin
      int n;
      n = 1;
      while (!bus.resp_valid_o && n < 20) begin
        tick();
        n++;
      end
    end
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_vld%0d", c), bus.resp_valid_o, 1);
      chk($sformatf("bp_res%0d", c), bus.result_o, 17'h05555);
      chk($sformatf("bp_id%0d", c),  bus.resp_id_o, 1);
      chk($sformatf("bp_gnt%0d", c), {bus.req1_ready_o, bus.req0_ready_o}, 2'b00);
      tick();
    end
    exp_q.push_back('{id: 1'b1, res: 17'h05555});
    bus.resp_ready_i = 1;
    wait_resp(-1, "bp");
    tick();
    chk("bp_release", bus.resp_valid_o, 0);
    chk("bp_arb_busy", bus.busy_o, 0);
    chk("bp_arb_gnt", {bus.req1_ready_o, bus.req0_ready_o}, 2'b01);

    // key load collides with a request in ARB
    bus.req1_valid_i = 0;
    bus.key_load_i = 1;
    #1;
    chk("coll_gnt", {bus.req1_ready_o, bus.req0_ready_o}, 2'b00);
    tick();
    bus.key_load_i = 0;
    bus.req0_valid_i = 0;
    chk("coll_key_valid", bus.key_valid_o, 0);
    chk("coll_busy", bus.busy_o, 1);
    chk("coll_add1", bus.add1_o, 16'h1234);
    chk("coll_key_hold", bus.key_o, key);

    // reset after 10 bits of the new load
    for (int i = 0; i < 10; i++) begin
      bus.key_bit_i = i[0];
      tick();
    end
    chk("mid_key_hold", bus.key_o, key);
    rst = 1;
    tick();
    rst = 0;
    bus.req0_valid_i = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mid_rst_gnt%0d", c), {bus.req1_ready_o, bus.req0_ready_o}, 2'b00);
      tick();
    end
    chk("mid_rst_key", bus.key_o, 0);
    chk("mid_rst_key_valid", bus.key_valid_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_resp", bus.resp_valid_o, 0);
    bus.req0_valid_i = 0;
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aca_lock_ctrl.md
ACA_LOCK_CTRL -- requirements
Module: aca_lock_ctrl

Parameters
REQ-001 KEY_W, 32, width of the locking key driven to the locked adder.
REQ-002 DATA_W, 16, operand width; result width is DATA_W+1.
REQ-003 SETTLE, 2, number of cycles (1..15) operands are held before the adder result is captured.

Interface
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 key_load_i  in  1  one-cycle pulse that starts a serial key load.
REQ-007 key_bit_i  in  1  serial key bit, MSB first, sampled on each LOAD cycle.
REQ-008 key_valid_o  out  1  high when key_o holds a completely loaded key.
REQ-009 req0_valid_i / req1_valid_i  in  1 each  requester operation valid.
REQ-010 req0_a_i, req0_b_i / req1_a_i, req1_b_i  in  DATA_W each  requester operands.
REQ-011 req0_ready_o / req1_ready_o  out  1 each  grant; the transfer occurs when valid and ready are both high.
REQ-012 add1_o, add2_o  out  DATA_W each  operands to the locked adder.
REQ-013 key_o  out  KEY_W  keyinput to the locked adder.
REQ-014 result_i  in  DATA_W+1  combinational result returned by the locked adder.
REQ-015 resp_valid_o  out  1  response available.
REQ-016 resp_id_o  out  1  index of the requester that owns the response.
REQ-017 result_o  out  DATA_W+1  captured adder result.
REQ-018 resp_ready_i  in  1  consumer accepts the response.
REQ-019 busy_o  out  1  high in every state except IDLE and ARB.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, LOAD, ARB, SETTLE, RESP.
REQ-021 IDLE:
- key_load_i goes to LOAD; no other exit.
- Both ready outputs are low.
REQ-022 LOAD:
- Runs exactly KEY_W cycles.
- Each cycle: shadow <= {shadow[KEY_W-2:0], key_bit_i}.
- Bit counter counts 0..KEY_W-1.
- On the last cycle: key_o <= final shadow value, key_valid_o <= 1, go to ARB.
REQ-023 key_o SHALL NOT change during LOAD; the key update is atomic at LOAD completion.
REQ-024 Entry to LOAD SHALL clear key_valid_o in the same edge.
REQ-025 key_load_i SHALL be ignored in LOAD, SETTLE and RESP (no queuing).
REQ-026 ARB, grant rule:
- Ready SHALL be asserted combinationally to exactly one valid requester.
- Only one requester valid: that requester is granted.
- Both valid: the requester with round-robin priority is granted.
REQ-027 Round-robin priority SHALL flip to the other requester after each accepted transfer; after reset, priority is requester 0.
REQ-028 ARB, simultaneous events: key_load_i high in ARB SHALL win; both ready outputs stay low that cycle and the FSM goes to LOAD.
REQ-029 On a transfer:
- add1_o/add2_o <= the granted operands.
- The id is latched.
- A settle counter is loaded with SETTLE.
- Go to SETTLE.
REQ-030 SETTLE:
- The counter decrements each cycle.
- When it reaches 1: result_o <= result_i, resp_id_o <= latched id, resp_valid_o <= 1, go to RESP.
- Total latency is SETTLE+1 cycles from the transfer edge to the first cycle of resp_valid_o.
REQ-031 RESP:
- result_o, resp_id_o and resp_valid_o SHALL be held stable until resp_ready_i is high.
- On that edge, resp_valid_o <= 0 and the FSM goes to ARB.
- No new grant in the same cycle.
REQ-032 add1_o/add2_o SHALL hold their last value outside transfers; key_o SHALL hold outside LOAD completion.
REQ-033 No arithmetic is performed in this block; result width is DATA_W+1 and passed unmodified.

Reset
REQ-034 On rst_i high at a clock edge, the following SHALL be reset:
- state=IDLE, key_o=0, shadow=0, key_valid_o=0.
- add1_o=add2_o=0, result_o=0, resp_valid_o=0, resp_id_o=0.
- priority=requester 0, both ready outputs low, busy_o=0.
REQ-035 Reset mid-LOAD, mid-SETTLE or mid-RESP SHALL abandon the operation; a pending response is discarded and the partially loaded key is never exposed.

Verification
REQ-036 Key load: reset, pulse key_load_i, shift 0x1812B8A4 MSB first over 32 cycles -> key_o=0x1812B8A4 and key_valid_o=1 on cycle 33; key_o=0 throughout the load.
REQ-037 Single op: req0 a=0x29AF b=0x7A1B with the adder modelled as a+b -> add1_o/add2_o driven; resp_valid_o 3 cycles after the transfer (SETTLE=2), result_o=0x0A3CA, resp_id_o=0.
REQ-038 Arbitration: both requesters valid continuously (req0 0x5555+0xAAAA, req1 0x8943+0xFFFF) -> grants alternate 0,1,0; results 0x0FFFF (id 0) and 0x18942 (id 1).
REQ-039 Backpressure: resp_ready_i low for 5 cycles -> result_o, resp_id_o and resp_valid_o stable and no grant; release -> one-cycle handshake, return to ARB.
REQ-040 Reset mid-LOAD after 10 bits, then a request -> key_o=0, key_valid_o=0, both ready outputs stay low (IDLE).
REQ-041 key_load_i and req0_valid_i high together in ARB -> no transfer, LOAD entered, key_valid_o=0 on the next cycle.
